// File: rtl/slice_serializer.sv
// Captures a NUM_SLICES*BUS_SIZE snapshot on start and streams it out one slice per valid/ready transfer.
// Build option: SLICE_SERIALIZER_MSB_FIRST_EN reverses emission order (highest slice first).
module slice_serializer #(
    parameter int unsigned BUS_SIZE   = 8,
    parameter int unsigned NUM_SLICES = 4,
    parameter int unsigned BITS_INDEX = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic                           i_start,
    input  logic [NUM_SLICES*BUS_SIZE-1:0] i_data,
    input  logic                           i_ready,
    output logic [BUS_SIZE-1:0]            o_data,
    output logic                           o_valid,
    output logic [BITS_INDEX-1:0]          o_index,
    output logic                           o_busy,
    output logic                           o_done
);

    localparam int unsigned DataW = NUM_SLICES * BUS_SIZE;

`ifdef SLICE_SERIALIZER_MSB_FIRST_EN
    localparam logic [BITS_INDEX-1:0] FirstIdx = BITS_INDEX'(NUM_SLICES - 1);
    localparam logic [BITS_INDEX-1:0] LastIdx  = '0;
    localparam logic [BITS_INDEX-1:0] StepIdx  = BITS_INDEX'(-1);
`else
    localparam logic [BITS_INDEX-1:0] FirstIdx = '0;
    localparam logic [BITS_INDEX-1:0] LastIdx  = BITS_INDEX'(NUM_SLICES - 1);
    localparam logic [BITS_INDEX-1:0] StepIdx  = BITS_INDEX'(1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [DataW-1:0]        snap_q;
    logic [BUS_SIZE-1:0]     data_q;
    logic                    valid_q;
    logic [BITS_INDEX-1:0]   index_q;
    logic                    busy_q;
    logic                    done_q;
    logic [BITS_INDEX-1:0]   index_d;

    // Mux one slice out of a bus; out-of-range indices (non power-of-two counts) yield zero.
    function automatic logic [BUS_SIZE-1:0] pick_slice(input logic [DataW-1:0]      bus,
                                                       input logic [BITS_INDEX-1:0] idx);
        logic [BUS_SIZE-1:0] res;
        res = '0;
        for (int unsigned k = 0; k < NUM_SLICES; k++) begin
            if (idx == BITS_INDEX'(k)) begin
                res = bus[k*BUS_SIZE +: BUS_SIZE];
            end
        end
        return res;
    endfunction

    assign index_d = index_q + StepIdx;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            snap_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            index_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        // First slice comes straight from the bus so it is visible on the next cycle.
                        snap_q  <= i_data;
                        index_q <= FirstIdx;
                        data_q  <= pick_slice(i_data, FirstIdx);
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (i_ready) begin
                        if (index_q == LastIdx) begin
                            data_q  <= '0;
                            valid_q <= 1'b0;
                            index_q <= '0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            index_q <= index_d;
                            data_q  <= pick_slice(snap_q, index_d);
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                    index_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_index = index_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_slice_serializer.sv
// Self-checking bench for slice_serializer: queue-based reference model plus directed literal checks.
// Honours SLICE_SERIALIZER_MSB_FIRST_EN for the expected emission order.
module tb_slice_serializer;

    logic        clk = 1'b0;
    logic        rst, start, ready;
    logic [31:0] din;
    logic [7:0]  dout;
    logic        valid, busy, done;
    logic [1:0]  idx;

    logic        start1, ready1;
    logic [7:0]  din1, dout1;
    logic        valid1, busy1, done1;
    logic [0:0]  idx1;

    always #5 clk = ~clk;

    slice_serializer #(.BUS_SIZE(8), .NUM_SLICES(4)) dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_data(din), .i_ready(ready),
        .o_data(dout), .o_valid(valid), .o_index(idx), .o_busy(busy), .o_done(done)
    );

    slice_serializer #(.BUS_SIZE(8), .NUM_SLICES(1)) dut1 (
        .i_clock(clk), .i_reset(rst), .i_start(start1), .i_data(din1), .i_ready(ready1),
        .o_data(dout1), .o_valid(valid1), .o_index(idx1), .o_busy(busy1), .o_done(done1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-written expected slice sequence for 32'hDDCCBBAA.
    function automatic logic [9:0] lit_slot(input int n);
        logic [7:0] lit [4];
        int k;
        lit = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef SLICE_SERIALIZER_MSB_FIRST_EN
        k = 3 - n;
`else
        k = n;
`endif
        return {lit[k], 2'(k)};
    endfunction

    // Reference model: a queue of slices still owed downstream.
    typedef struct {
        logic [7:0] d;
        logic [1:0] i;
    } slot_t;
    slot_t mq[$];
    int    phase = 0;  // 0 idle, 1 sending, 2 done pulse

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            phase = 0;
        end else begin
            case (phase)
                0: if (start) begin
`ifdef SLICE_SERIALIZER_MSB_FIRST_EN
                    for (int k = 3; k >= 0; k--) mq.push_back('{din[k*8 +: 8], 2'(k)});
`else
                    for (int k = 0; k < 4; k++) mq.push_back('{din[k*8 +: 8], 2'(k)});
`endif
                    phase = 1;
                end
                1: if (ready) begin
                    void'(mq.pop_front());
                    if (mq.size() == 0) phase = 2;
                end
                default: phase = 0;
            endcase
        end
    end

    int         cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit         chk_en = 1'b0;
    logic [9:0] logq[$];
    int         n_done = 0;
    int         done_cyc = -1;
    int         hold_cnt = 0;
    logic [1:0] hold_idx;

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid", 32'(valid), 32'(phase == 1));
            check("busy",  32'(busy),  32'(phase != 0));
            check("done",  32'(done),  32'(phase == 2));
            check("data",  32'(dout),  32'(phase == 1 ? mq[0].d : 8'h00));
            if (phase == 1) check("index", 32'(idx), 32'(mq[0].i));
            if (valid && ready && !rst) logq.push_back({dout, idx});
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (valid && idx == hold_idx) hold_cnt++;
        end
    end

    task automatic check_log(input string tag, input int first, input int cnt);
        for (int n = 0; n < cnt; n++) begin
            if (first + n < logq.size()) check(tag, 32'(logq[first+n]), 32'(lit_slot(n)));
            else check({tag, "_missing"}, 32'(logq.size()), 32'(first + n + 1));
        end
    endtask

    task automatic clear_stats();
        logq.delete();
        n_done   = 0;
        hold_cnt = 0;
        done_cyc = -1;
    endtask

    initial begin
        int start_cyc;
        logic [9:0] s1;
        s1       = lit_slot(1);
        hold_idx = s1[1:0];
        rst = 1'b1; start = 1'b0; ready = 1'b1; din = 32'hDDCCBBAA;
        start1 = 1'b0; ready1 = 1'b1; din1 = 8'h5A;
        step();
        chk_en = 1'b1;
        step();
        check("rst_data",  32'(dout),  32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_index", 32'(idx),   32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_done",  32'(done),  32'h0);
        rst = 1'b0;
        step();

        // Straight dump with ready high.
        clear_stats();
        start = 1'b1; start_cyc = cyc;
        step();
        start = 1'b0;
        repeat (8) step();
        check("t1_count", 32'(logq.size()), 32'd4);
        check_log("t1_slot", 0, 4);
        check("t1_done_cnt", 32'(n_done), 32'd1);
        check("t1_done_cyc", 32'(done_cyc), 32'(start_cyc + 5));

        // Backpressure on the second slice.
        clear_stats();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        ready = 1'b0;
        repeat (3) step();
        ready = 1'b1;
        repeat (8) step();
        check("t2_count", 32'(logq.size()), 32'd4);
        check_log("t2_slot", 0, 4);
        check("t2_hold", 32'(hold_cnt), 32'd4);
        check("t2_done_cnt", 32'(n_done), 32'd1);

        // Bus changes after capture must not leak through.
        clear_stats();
        start = 1'b1;
        step();
        start = 1'b0;
        din = 32'h11223344;
        repeat (8) step();
        check_log("t3_slot", 0, 4);
        din = 32'hDDCCBBAA;

        // Start held through SEND and DONE is ignored; a start in IDLE restarts.
        clear_stats();
        start = 1'b1;
        repeat (6) step();
        start = 1'b0;
        repeat (3) step();
        check("t4_count", 32'(logq.size()), 32'd4);
        check("t4_done_cnt", 32'(n_done), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        check("t4_count2", 32'(logq.size()), 32'd8);
        check_log("t4_slot2", 4, 4);
        check("t4_done_cnt2", 32'(n_done), 32'd2);

        // Reset while the third slice is presented.
        clear_stats();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        check("t5_data",  32'(dout),  32'h0);
        check("t5_valid", 32'(valid), 32'h0);
        check("t5_index", 32'(idx),   32'h0);
        check("t5_busy",  32'(busy),  32'h0);
        check("t5_done",  32'(done),  32'h0);
        rst = 1'b0;
        step();
        check("t5_partial", 32'(logq.size()), 32'd2);
        check("t5_no_done", 32'(n_done), 32'd0);
        clear_stats();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        check_log("t5_slot", 0, 4);
        check("t5_done_cnt", 32'(n_done), 32'd1);

        // Single-slice instance.
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        check("n1_valid", 32'(valid1), 32'h1);
        check("n1_data",  32'(dout1),  32'h5A);
        check("n1_index", 32'(idx1),   32'h0);
        check("n1_busy",  32'(busy1),  32'h1);
        step();
        check("n1_done",  32'(done1),  32'h1);
        check("n1_valid_off", 32'(valid1), 32'h0);
        check("n1_data_off",  32'(dout1),  32'h0);
        step();
        check("n1_idle_busy", 32'(busy1), 32'h0);
        check("n1_idle_done", 32'(done1), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
